// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter: one single-bit shift step per clock, amount 0..15.
// Latency: n+1 cycles from accepting edge to done (n = 0 for pass or amt=0, else amt).
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped, no queuing.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, in, op, amt   request strobe and operands, latched on acceptance in IDLE
//   busy, done, out      state decodes and the held result register
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;

    // Single-bit shift using the datapath shifter's op encoding.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] a,
                                              input logic [1:0]       o);
        logic [WIDTH-1:0] r;
        case (o)
            2'b01:   r = {a[WIDTH-2:0], 1'b0};
            2'b10:   r = {1'b0, a[WIDTH-1:1]};
            2'b11:   r = {a[WIDTH-1], a[WIDTH-1:1]};
            default: r = a;
        endcase
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= 2'b00;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = in;
                    op_d  = op;
                    cnt_d = amt;
                    // Zero-step requests skip RUN and publish the operand directly.
                    if (amt == '0 || op == 2'b00) begin
                        state_d = DONE;
                        out_d   = in;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = step(acc_q, op_q);
                cnt_d = cnt_q - AMT_W'(1);
                // cnt_q counts steps still to apply including this one.
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                    out_d   = step(acc_q, op_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        out  = out_q;
    end

endmodule
